// File: rtl/noc_pkg.sv
// Shared definitions for the mesh network interface blocks.
//   FLIT_W / LOC_W : flit and tile-address widths
//   flit_t         : single-flit packet layout {dest, payload}
//   loc_legal()    : an address is legal when each nibble is one-hot
//   ERR_*          : bit positions inside the sticky error vector
package noc_pkg;

  localparam int FLIT_W = 16;
  localparam int LOC_W  = 8;

  typedef struct packed {
    logic [7:0] dest;
    logic [7:0] payload;
  } flit_t;

  localparam int ERR_RX_OVERFLOW   = 0;
  localparam int ERR_MISROUTE      = 1;
  localparam int ERR_CREDIT_OVERFL = 2;
  localparam int ERR_BAD_DEST      = 3;

  // X lives in [7:4], Y in [3:0]; each must have exactly one bit set.
  function automatic logic loc_legal(input logic [LOC_W-1:0] loc);
    logic [3:0] x;
    logic [3:0] y;
    x = loc[7:4];
    y = loc[3:0];
    return (x != 4'd0) && ((x & (x - 4'd1)) == 4'd0) &&
           (y != 4'd0) && ((y & (y - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Synchronous show-ahead FIFO.
//   clk, rst    : clock, synchronous active-high reset
//   push, din   : write request and data (ignored while full unless popping)
//   pop, dout   : read request; dout always shows the head entry
//   full, empty : occupancy flags
// DEPTH must be a power of 2; pointers carry one extra MSB so that
// full and empty can be told apart when the index bits match.
module noc_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop & ~empty;
  // A pop frees the slot this cycle, so a simultaneous push is accepted
  // even when full.
  assign wr_en = push & (~full | rd_en);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // NOTE: storage is not reset; validity is tracked solely by the pointers,
  // and leaving the array out of reset lets it map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

  // NOTE: sequential state always uses <= so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/noc_local_ni.sv
// Network interface for one tile's local router port.
//   tx_*        : client request -> single-flit packet injected on noc_flit_o
//   rx_*        : show-ahead RX FIFO of flits ejected by the router
//   noc_*_o/_i  : router local port (flit, valid, credit return)
//   credits_o   : TX credits currently held toward the router
//   err_o       : sticky {bad_dest, credit_overflow, misroute, rx_overflow}
module noc_local_ni
  import noc_pkg::*;
#(
  parameter logic [7:0] LOCATION   = 8'b0001_0001,
  parameter int         TX_CREDITS = 4,
  parameter int         RX_DEPTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [7:0]                        tx_dest,
  input  logic [7:0]                        tx_payload,
  input  logic                              tx_valid,
  output logic                              tx_ready,
  output logic [15:0]                       rx_flit,
  output logic                              rx_valid,
  input  logic                              rx_ready,
  output logic [15:0]                       noc_flit_o,
  output logic                              noc_valid_o,
  input  logic                              noc_incr_i,
  input  logic [15:0]                       noc_flit_i,
  input  logic                              noc_valid_i,
  output logic                              noc_incr_o,
  output logic [$clog2(TX_CREDITS+1)-1:0]   credits_o,
  output logic [3:0]                        err_o
);

  localparam int CW = $clog2(TX_CREDITS + 1);
  localparam int PW = $clog2(RX_DEPTH + 1);

  // ---------------------------------------------------------------- TX path
  logic [CW-1:0] credits;
  logic          credits_full;
  logic          tx_accept;
  logic          tx_send;
  logic          tx_bad;
  logic          credit_ovf;
  flit_t         tx_flit;

  assign tx_ready       = (credits != '0);
  assign tx_accept      = tx_valid & tx_ready;
  assign tx_send        = tx_accept & loc_legal(tx_dest);
  // Illegal destinations are consumed (handshake completes) but never sent.
  assign tx_bad         = tx_accept & ~loc_legal(tx_dest);
  assign credits_full   = (credits == CW'(TX_CREDITS));
  assign credit_ovf     = noc_incr_i & ~tx_send & credits_full;
  assign tx_flit.dest    = tx_dest;
  assign tx_flit.payload = tx_payload;
  assign credits_o      = credits;

  always_ff @(posedge clk) begin
    if (rst) begin
      credits     <= CW'(TX_CREDITS);
      noc_valid_o <= 1'b0;
      noc_flit_o  <= '0;
    end else begin
      noc_valid_o <= tx_send;
      if (tx_send) noc_flit_o <= tx_flit;
      // Send and credit return in the same cycle cancel out.
      case ({tx_send, noc_incr_i})
        2'b10:   credits <= credits - CW'(1);
        2'b01:   if (!credits_full) credits <= credits + CW'(1);
        default: credits <= credits;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX path
  flit_t         rx_in;
  logic          rx_match;
  logic          misroute;
  logic          rx_pop;
  logic          rx_push;
  logic          rx_overflow;
  logic          fifo_full;
  logic          fifo_empty;
  logic [15:0]   fifo_dout;
  logic [PW-1:0] pending;
  logic [PW-1:0] pending_next;

  assign rx_in       = noc_flit_i;
  assign rx_match    = noc_valid_i & (rx_in.dest == LOCATION);
  assign misroute    = noc_valid_i & (rx_in.dest != LOCATION);
  assign rx_pop      = ~fifo_empty & rx_ready;
  assign rx_push     = rx_match & (~fifo_full | rx_pop);
  assign rx_overflow = rx_match & fifo_full & ~rx_pop;

  noc_sync_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (noc_flit_i),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rx_valid = ~fifo_empty;
  // Storage is not reset, so mask the head while nothing valid is there.
  assign rx_flit  = fifo_empty ? '0 : fifo_dout;

  // Credits owed to the router: one per slot freed by a pop, one per
  // misrouted flit discarded; returned one per cycle.
  assign pending_next = pending + PW'(rx_pop) + PW'(misroute) - PW'(noc_incr_o);

  always_ff @(posedge clk) begin
    if (rst) begin
      pending    <= '0;
      noc_incr_o <= 1'b0;
    end else begin
      pending    <= pending_next;
      // Pulse again only if credits remain beyond the one being returned now.
      noc_incr_o <= (pending != PW'(noc_incr_o));
    end
  end

  // --------------------------------------------------------------- errors
  logic [3:0] err_set;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    err_set                    = '0;
    err_set[ERR_RX_OVERFLOW]   = rx_overflow;
    err_set[ERR_MISROUTE]      = misroute;
    err_set[ERR_CREDIT_OVERFL] = credit_ovf;
    err_set[ERR_BAD_DEST]      = tx_bad;
  end

  always_ff @(posedge clk) begin
    if (rst) err_o <= '0;
    else     err_o <= err_o | err_set;
  end

endmodule

// File: tb/tb_noc_local_ni.sv
// Directed self-checking bench for noc_local_ni (LOCATION=8'h11,
// TX_CREDITS=4, RX_DEPTH=4). Inputs change 1 time unit after the rising
// edge; outputs are sampled at that same point.
module tb_noc_local_ni;

  logic        clk;
  logic        rst;
  logic [7:0]  tx_dest;
  logic [7:0]  tx_payload;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] rx_flit;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] noc_flit_o;
  logic        noc_valid_o;
  logic        noc_incr_i;
  logic [15:0] noc_flit_i;
  logic        noc_valid_i;
  logic        noc_incr_o;
  logic [2:0]  credits_o;
  logic [3:0]  err_o;

  int n_cmp = 0;
  int n_bad = 0;

  noc_local_ni #(
    .LOCATION   (8'h11),
    .TX_CREDITS (4),
    .RX_DEPTH   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_dest     (tx_dest),
    .tx_payload  (tx_payload),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_flit     (rx_flit),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .noc_flit_o  (noc_flit_o),
    .noc_valid_o (noc_valid_o),
    .noc_incr_i  (noc_incr_i),
    .noc_flit_i  (noc_flit_i),
    .noc_valid_i (noc_valid_i),
    .noc_incr_o  (noc_incr_o),
    .credits_o   (credits_o),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++; if (credits_o !== 3'd4) begin n_bad++; $display("FAIL reset_credits: got %0d want 4", credits_o); end
    n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
    n_cmp++; if (noc_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_noc_valid: got %b want 0", noc_valid_o); end
    n_cmp++; if (noc_flit_o !== 16'h0000) begin n_bad++; $display("FAIL reset_noc_flit: got %h want 0000", noc_flit_o); end
    n_cmp++; if (noc_incr_o !== 1'b0) begin n_bad++; $display("FAIL reset_noc_incr: got %b want 0", noc_incr_o); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    n_cmp++; if (rx_flit !== 16'h0000) begin n_bad++; $display("FAIL reset_rx_flit: got %h want 0000", rx_flit); end
    n_cmp++; if (err_o !== 4'b0000) begin n_bad++; $display("FAIL reset_err: got %b want 0000", err_o); end
  endtask

  // Hold a legal request for 5 cycles with no credit return.
  task automatic test_tx_burst();
    int       pulses;
    logic     exp_ready;
    logic [2:0] exp_cr;
    pulses     = 0;
    tx_dest    = 8'h24;
    tx_payload = 8'hA5;
    tx_valid   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_ready = (i < 4);
      exp_cr    = (i < 4) ? 3'(3 - i) : 3'd0;
      n_cmp++; if (tx_ready !== exp_ready) begin n_bad++; $display("FAIL burst_tx_ready[%0d]: got %b want %b", i, tx_ready, exp_ready); end
      tick();
      if (noc_valid_o === 1'b1) pulses++;
      n_cmp++; if (credits_o !== exp_cr) begin n_bad++; $display("FAIL burst_credits[%0d]: got %0d want %0d", i, credits_o, exp_cr); end
      n_cmp++; if (noc_flit_o !== 16'h24A5) begin n_bad++; $display("FAIL burst_flit[%0d]: got %h want 24a5", i, noc_flit_o); end
    end
    tx_valid = 1'b0;
    n_cmp++; if (pulses !== 4) begin n_bad++; $display("FAIL burst_pulses: got %0d want 4", pulses); end
  endtask

  task automatic test_credit_return();
    n_cmp++; if (tx_ready !== 1'b0) begin n_bad++; $display("FAIL cr_ready_at_zero: got %b want 0", tx_ready); end
    noc_incr_i = 1'b1;
    tick();
    noc_incr_i = 1'b0;
    n_cmp++; if (credits_o !== 3'd1) begin n_bad++; $display("FAIL cr_after_incr: got %0d want 1", credits_o); end
    n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL cr_ready_after_incr: got %b want 1", tx_ready); end
    tx_dest = 8'h24; tx_payload = 8'h5A; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    n_cmp++; if (noc_valid_o !== 1'b1) begin n_bad++; $display("FAIL cr_send_valid: got %b want 1", noc_valid_o); end
    n_cmp++; if (noc_flit_o !== 16'h245A) begin n_bad++; $display("FAIL cr_send_flit: got %h want 245a", noc_flit_o); end
    n_cmp++; if (credits_o !== 3'd0) begin n_bad++; $display("FAIL cr_send_credits: got %0d want 0", credits_o); end
    noc_incr_i = 1'b1;
    tick();
    // Send and credit return together: count must not move.
    tx_payload = 8'h6B; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0; noc_incr_i = 1'b0;
    n_cmp++; if (credits_o !== 3'd1) begin n_bad++; $display("FAIL cr_same_cycle: got %0d want 1", credits_o); end
    n_cmp++; if (noc_valid_o !== 1'b1) begin n_bad++; $display("FAIL cr_same_cycle_valid: got %b want 1", noc_valid_o); end
    tick();
    n_cmp++; if (noc_valid_o !== 1'b0) begin n_bad++; $display("FAIL cr_valid_drop: got %b want 0", noc_valid_o); end
    n_cmp++; if (noc_flit_o !== 16'h246B) begin n_bad++; $display("FAIL cr_flit_hold: got %h want 246b", noc_flit_o); end
    noc_incr_i = 1'b1;
    tick(); tick(); tick();
    noc_incr_i = 1'b0;
    n_cmp++; if (credits_o !== 3'd4) begin n_bad++; $display("FAIL cr_refill: got %0d want 4", credits_o); end
    n_cmp++; if (err_o !== 4'b0000) begin n_bad++; $display("FAIL cr_no_err: got %b want 0000", err_o); end
  endtask

  // Destination equal to this tile is still injected.
  task automatic test_self_loop();
    tx_dest = 8'h11; tx_payload = 8'hC3; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    n_cmp++; if (noc_valid_o !== 1'b1) begin n_bad++; $display("FAIL self_valid: got %b want 1", noc_valid_o); end
    n_cmp++; if (noc_flit_o !== 16'h11C3) begin n_bad++; $display("FAIL self_flit: got %h want 11c3", noc_flit_o); end
    n_cmp++; if (credits_o !== 3'd3) begin n_bad++; $display("FAIL self_credits: got %0d want 3", credits_o); end
    noc_incr_i = 1'b1;
    tick();
    noc_incr_i = 1'b0;
  endtask

  task automatic test_rx_basic();
    noc_valid_i = 1'b1; noc_flit_i = 16'h1133;
    tick();
    noc_flit_i = 16'h1144;
    tick();
    noc_valid_i = 1'b0;
    n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL rx_valid: got %b want 1", rx_valid); end
    n_cmp++; if (rx_flit !== 16'h1133) begin n_bad++; $display("FAIL rx_head: got %h want 1133", rx_flit); end
    n_cmp++; if (noc_incr_o !== 1'b0) begin n_bad++; $display("FAIL rx_no_incr0: got %b want 0", noc_incr_o); end
    tick();
    n_cmp++; if (noc_incr_o !== 1'b0) begin n_bad++; $display("FAIL rx_no_incr1: got %b want 0", noc_incr_o); end
    rx_ready = 1'b1;
    tick();
    n_cmp++; if (rx_flit !== 16'h1144) begin n_bad++; $display("FAIL rx_second_head: got %h want 1144", rx_flit); end
    n_cmp++; if (noc_incr_o !== 1'b0) begin n_bad++; $display("FAIL rx_incr_lag: got %b want 0", noc_incr_o); end
    tick();
    rx_ready = 1'b0;
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL rx_empty: got %b want 0", rx_valid); end
    n_cmp++; if (noc_incr_o !== 1'b1) begin n_bad++; $display("FAIL rx_incr_a: got %b want 1", noc_incr_o); end
    tick();
    n_cmp++; if (noc_incr_o !== 1'b1) begin n_bad++; $display("FAIL rx_incr_b: got %b want 1", noc_incr_o); end
    tick();
    n_cmp++; if (noc_incr_o !== 1'b0) begin n_bad++; $display("FAIL rx_incr_end: got %b want 0", noc_incr_o); end
    tick();
  endtask

  // Misrouted flit arriving in the same cycle as a pop: two credits owed.
  task automatic test_misroute();
    noc_valid_i = 1'b1; noc_flit_i = 16'h1155;
    tick();
    noc_flit_i = 16'h2277; rx_ready = 1'b1;
    tick();
    noc_valid_i = 1'b0; rx_ready = 1'b0;
    n_cmp++; if (err_o !== 4'b0010) begin n_bad++; $display("FAIL mis_err: got %b want 0010", err_o); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL mis_not_stored: got %b want 0", rx_valid); end
    n_cmp++; if (noc_incr_o !== 1'b0) begin n_bad++; $display("FAIL mis_incr0: got %b want 0", noc_incr_o); end
    tick();
    n_cmp++; if (noc_incr_o !== 1'b1) begin n_bad++; $display("FAIL mis_incr1: got %b want 1", noc_incr_o); end
    tick();
    n_cmp++; if (noc_incr_o !== 1'b1) begin n_bad++; $display("FAIL mis_incr2: got %b want 1", noc_incr_o); end
    tick();
    n_cmp++; if (noc_incr_o !== 1'b0) begin n_bad++; $display("FAIL mis_incr3: got %b want 0", noc_incr_o); end
  endtask

  task automatic test_overflow();
    int          pulses;
    logic [15:0] exp_q [4];
    exp_q  = '{16'h1102, 16'h1103, 16'h1104, 16'h1106};
    pulses = 0;
    noc_valid_i = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      noc_flit_i = 16'h1100 + 16'(i);
      tick();
      if (noc_incr_o === 1'b1) pulses++;
    end
    noc_valid_i = 1'b0;
    n_cmp++; if (err_o !== 4'b0011) begin n_bad++; $display("FAIL ovf_err: got %b want 0011", err_o); end
    n_cmp++; if (rx_flit !== 16'h1101) begin n_bad++; $display("FAIL ovf_head: got %h want 1101", rx_flit); end
    // Push into a full FIFO while popping is accepted.
    noc_valid_i = 1'b1; noc_flit_i = 16'h1106; rx_ready = 1'b1;
    tick();
    noc_valid_i = 1'b0;
    if (noc_incr_o === 1'b1) pulses++;
    n_cmp++; if (err_o !== 4'b0011) begin n_bad++; $display("FAIL ovf_full_pop_err: got %b want 0011", err_o); end
    for (int j = 0; j < 4; j++) begin
      n_cmp++; if (rx_valid !== 1'b1 || rx_flit !== exp_q[j]) begin n_bad++; $display("FAIL ovf_drain[%0d]: got %b/%h want 1/%h", j, rx_valid, rx_flit, exp_q[j]); end
      tick();
      if (noc_incr_o === 1'b1) pulses++;
    end
    rx_ready = 1'b0;
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_empty: got %b want 0", rx_valid); end
    for (int k = 0; k < 6; k++) begin
      tick();
      if (noc_incr_o === 1'b1) pulses++;
    end
    n_cmp++; if (pulses !== 5) begin n_bad++; $display("FAIL ovf_credit_count: got %0d want 5", pulses); end
  endtask

  task automatic test_bad_dest();
    tx_dest = 8'h33; tx_payload = 8'h99; tx_valid = 1'b1;
    n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL bad_ready: got %b want 1", tx_ready); end
    tick();
    tx_valid = 1'b0;
    n_cmp++; if (noc_valid_o !== 1'b0) begin n_bad++; $display("FAIL bad_valid: got %b want 0", noc_valid_o); end
    n_cmp++; if (err_o !== 4'b1011) begin n_bad++; $display("FAIL bad_err: got %b want 1011", err_o); end
    n_cmp++; if (credits_o !== 3'd4) begin n_bad++; $display("FAIL bad_credits: got %0d want 4", credits_o); end
    n_cmp++; if (noc_flit_o !== 16'h11C3) begin n_bad++; $display("FAIL bad_flit_hold: got %h want 11c3", noc_flit_o); end
  endtask

  task automatic test_credit_overflow();
    noc_incr_i = 1'b1;
    tick();
    noc_incr_i = 1'b0;
    n_cmp++; if (credits_o !== 3'd4) begin n_bad++; $display("FAIL covf_credits: got %0d want 4", credits_o); end
    n_cmp++; if (err_o !== 4'b1111) begin n_bad++; $display("FAIL covf_err: got %b want 1111", err_o); end
  endtask

  task automatic test_mid_reset();
    tx_dest = 8'h24; tx_payload = 8'h11; tx_valid = 1'b1;
    noc_valid_i = 1'b1; noc_flit_i = 16'h1177;
    tick();
    n_cmp++; if (noc_valid_o !== 1'b1 || rx_valid !== 1'b1) begin n_bad++; $display("FAIL mr_traffic: got %b/%b want 1/1", noc_valid_o, rx_valid); end
    rst = 1'b1;
    tick();
    n_cmp++; if (credits_o !== 3'd4) begin n_bad++; $display("FAIL mr_credits: got %0d want 4", credits_o); end
    n_cmp++; if (noc_valid_o !== 1'b0) begin n_bad++; $display("FAIL mr_valid: got %b want 0", noc_valid_o); end
    n_cmp++; if (noc_flit_o !== 16'h0000) begin n_bad++; $display("FAIL mr_flit: got %h want 0000", noc_flit_o); end
    n_cmp++; if (noc_incr_o !== 1'b0) begin n_bad++; $display("FAIL mr_incr: got %b want 0", noc_incr_o); end
    n_cmp++; if (rx_valid !== 1'b0 || rx_flit !== 16'h0000) begin n_bad++; $display("FAIL mr_rx: got %b/%h want 0/0000", rx_valid, rx_flit); end
    n_cmp++; if (err_o !== 4'b0000) begin n_bad++; $display("FAIL mr_err: got %b want 0000", err_o); end
    rst = 1'b0; tx_valid = 1'b0; noc_valid_i = 1'b0;
    tick();
    n_cmp++; if (noc_valid_o !== 1'b0 || rx_valid !== 1'b0) begin n_bad++; $display("FAIL mr_after: got %b/%b want 0/0", noc_valid_o, rx_valid); end
  endtask

  initial begin
    rst         = 1'b1;
    tx_dest     = 8'h00;
    tx_payload  = 8'h00;
    tx_valid    = 1'b0;
    rx_ready    = 1'b0;
    noc_incr_i  = 1'b0;
    noc_flit_i  = 16'h0000;
    noc_valid_i = 1'b0;

    test_reset();
    test_tx_burst();
    test_credit_return();
    test_self_loop();
    test_rx_basic();
    test_misroute();
    test_overflow();
    test_bad_dest();
    test_credit_overflow();
    test_mid_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/noc_local_ni.md
Name: noc_local_ni

Overview:
Network interface for one tile's local router port. It packs client requests into 16-bit single-flit packets and injects them into the router's local input. It manages the router's credit-based flow control, and ejects flits arriving from the router into an RX FIFO that the client drains. One instance sits beside each of the 16 mesh routers at the chip top.

Parameters:
LOCATION, 8'b00010001, this tile's address: [7:4] one-hot X, [3:0] one-hot Y.
TX_CREDITS, 4, depth of the router's local input buffer; initial credit count.
RX_DEPTH, 4, RX FIFO depth; equals the credits the router holds toward this NI; power of 2, at least 2.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
tx_dest  in  8  destination address, same encoding as LOCATION
tx_payload  in  8  payload byte
tx_valid  in  1  client request
tx_ready  out  1  NI accepts the request this cycle
rx_flit  out  16  head flit of the RX FIFO
rx_valid  out  1  RX FIFO not empty
rx_ready  in  1  client pops the head flit
noc_flit_o  out  16  flit to the router's local_i
noc_valid_o  out  1  flit valid, to the router's valid_l_i
noc_incr_i  in  1  credit return from the router's l_incr_o; one pulse frees one slot
noc_flit_i  in  16  flit from the router's local_o
noc_valid_i  in  1  from the router's valid_l_o
noc_incr_o  out  1  credit return to the router's l_incr_i
credits_o  out  $clog2(TX_CREDITS+1)  current TX credit count
err_o  out  4  sticky flags: [0] rx_overflow, [1] misroute, [2] credit_overflow, [3] bad_dest

Behaviour:
- Flit format: [15:8] destination, [7:0] payload. A destination is legal only when each nibble is exactly one-hot.
- Reset values: credits_o=TX_CREDITS; noc_valid_o=0; noc_flit_o=0; noc_incr_o=0; RX FIFO empty (rx_valid=0, rx_flit=0); pending credit counter=0; err_o=0.
- Reset mid-operation discards everything in flight. The router shares rst, so both sides restart consistent.

TX path:
- tx_ready = (credits != 0). It is combinational from the credit register and never depends on tx_valid.
- Accept = tx_valid & tx_ready.
  - Legal destination: the next cycle drives noc_valid_o=1 and noc_flit_o={tx_dest,tx_payload}, and credits decrement.
  - Illegal destination: the request is consumed and dropped, err_o[3] is set, and credits and noc_valid_o are unchanged.
- noc_valid_o is a registered single-cycle pulse per flit. Back-to-back accepts give back-to-back pulses.
- noc_flit_o holds its last value when noc_valid_o=0.
- Credit update:
  - next = credits - send + noc_incr_i; a send and an increment in the same cycle leave credits unchanged.
  - An increment while credits==TX_CREDITS and no send saturates at TX_CREDITS and sets err_o[2].
- credits==0: tx_ready=0 until the first noc_incr_i; credits increase the cycle after the pulse.
- A destination equal to LOCATION is still injected; the router loops it back.

RX path:
- On noc_valid_i, the NI compares noc_flit_i[15:8] with LOCATION.
  - Mismatch: the flit is dropped, err_o[1] is set, and one credit is queued for return.
  - Match: the flit is pushed into the RX FIFO.
- FIFO behaviour:
  - Show-ahead: rx_valid = !empty and rx_flit = head.
  - Pop on rx_valid & rx_ready.
  - Push while full is accepted only if a pop occurs the same cycle. Otherwise the flit is dropped and err_o[0] is set, with no credit queued.
- Pending credit counter, width $clog2(RX_DEPTH+1):
  - Adds 1 per pop and 1 per misroute drop; up to 2 per cycle.
  - Subtracts 1 each cycle that noc_incr_o is driven.
  - noc_incr_o is registered: it pulses 1 in the cycle after pending>0 is observed, and at most one pulse per cycle.
- Pointer wrap: RX_DEPTH is a power of 2, so pointers wrap naturally; full/empty are distinguished by an extra MSB.

Decomposition:
- noc_pkg holds:
  - FLIT_W=16 and LOC_W=8.
  - Packed struct flit_t {logic [7:0] dest; logic [7:0] payload}.
  - Function loc_legal(loc) implementing the one-hot-per-nibble check.
  - Error bit index constants.
- Sub-module noc_sync_fifo (parameters WIDTH and DEPTH; ports push, pop, din, dout, full, empty) implements the RX FIFO and is reused elsewhere.
- The credit counter and the TX register stay inline.

Test Plan:
- Reset, then tx_valid held with dest=8'h24, payload=8'hA5 for 5 cycles, no noc_incr_i -> 4 pulses of noc_valid_o with flit 16'h24A5; credits_o 4→0; tx_ready=0 on the 5th cycle.
- From credits=0, pulse noc_incr_i once -> credits_o=1 next cycle; one more flit accepted. A send and noc_incr_i in the same cycle -> credits unchanged.
- LOCATION=8'h11; inject 16'h1133 and 16'h1144 on noc_valid_i with rx_ready=0 -> rx_valid=1, rx_flit=16'h1133, no noc_incr_o. Pop twice -> two noc_incr_o pulses, one per cycle.
- Inject 16'h2277 (misroute) in the same cycle as a pop -> err_o[1]=1; two pending credits produce noc_incr_o high for 2 consecutive cycles.
- Fill RX FIFO with 4 flits, inject a 5th with no pop -> err_o[0]=1, FIFO content unchanged, no extra credit. tx_dest=8'h33 -> request consumed, err_o[3]=1, no noc_valid_o.
- noc_incr_i while credits=4 -> err_o[2]=1, credits stay 4. Assert rst mid-traffic -> all outputs return to reset values the next cycle.
